// File: rtl/ibex_register_file_fpga_init.sv
// Write-port front-end for a reset-less FPGA register file.
// After each reset a background sweep writes WordZeroVal into every
// architectural register. Core writes take priority over the sweep. A valid
// bitmap masks read data from registers not written since reset, so stale
// contents are never visible and the core never stalls.
//
// Handshake: there is no valid/ready pairing on this block. A core write
// (we_a_i) is always accepted in the cycle it is presented. rf_we_o is a
// single-cycle write strobe that the register file must honour on the same
// clock edge.
module ibex_register_file_fpga_init #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_a_i,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 init_done_o,
  output logic                 err_o
);

  localparam int unsigned          AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned          NumRegs   = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastReg   = AddrWidth'(NumRegs - 1);

  typedef enum logic {
    SWEEP = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e               state_q;
  logic                 init_done_q;
  logic [NumRegs-1:1]   vld_q;
  logic [AddrWidth-1:0] ptr_q;

  logic                 in_range;
  logic                 core_wr;
  logic                 sweep_wr;
  logic [AddrWidth-1:0] widx;
  logic [31:0]          vld_full;

  // Upper half of the 5-bit address space does not exist in RV32E.
  assign in_range = !RV32E || !waddr_a_i[4];
  assign widx     = waddr_a_i[AddrWidth-1:0];
  assign core_wr  = rst_ni && we_a_i && (waddr_a_i != 5'd0) && in_range;
  // The sweep only writes registers the core has not already written.
  assign sweep_wr = rst_ni && (state_q == SWEEP) && !core_wr && !vld_q[ptr_q];

  // Write port mux: core first, otherwise the sweep values (also the idle values).
  assign rf_we_o     = core_wr || sweep_wr;
  assign rf_waddr_o  = core_wr ? waddr_a_i : 5'(ptr_q);
  assign rf_wdata_o  = core_wr ? wdata_a_i : WordZeroVal;
  assign err_o       = rst_ni && RV32E && we_a_i && waddr_a_i[4];
  assign init_done_o = init_done_q;

  // Sweep FSM, pointer and valid bitmap; the sweep stalls on core writes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SWEEP;
      init_done_q <= 1'b0;
      ptr_q       <= AddrWidth'(1);
      vld_q       <= '0;
    end else if (core_wr) begin
      vld_q[widx] <= 1'b1;
    end else begin
      case (state_q)
        SWEEP: begin
          if (sweep_wr) begin
            vld_q[ptr_q] <= 1'b1;
          end
          if (ptr_q == LastReg) begin
            state_q     <= DONE;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AddrWidth'(1);
          end
        end
        DONE: begin
          state_q     <= DONE;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= SWEEP;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Full 32-entry validity view: x0 always valid, nonexistent registers never valid.
  always_comb begin
    vld_full    = '0;
    vld_full[0] = 1'b1;
    for (int i = 1; i < NumRegs; i++) begin
      vld_full[i] = vld_q[i];
    end
  end

  // Read masking: unwritten registers read as WordZeroVal, no added latency.
  assign rdata_a_o = vld_full[raddr_a_i] ? rf_rdata_a_i : WordZeroVal;
  assign rdata_b_o = vld_full[raddr_b_i] ? rf_rdata_b_i : WordZeroVal;

endmodule

// File: tb/tb_ibex_register_file_fpga_init.sv
// Bench for ibex_register_file_fpga_init: one RV32I and one RV32E instance
// share the core-side inputs; each has its own register file model.
module tb_ibex_register_file_fpga_init;

  localparam logic [31:0] WZV  = 32'hDEADBEEF;
  localparam logic [31:0] PRE  = 32'hAAAAAAAA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;

  logic [1:0][31:0] rf_rdata_a, rf_rdata_b, rdata_a, rdata_b, rf_wdata;
  logic [1:0][4:0]  rf_waddr;
  logic [1:0]       rf_we, init_done, err;

  logic [31:0] mem [2][32];

  int vec = 0;
  int fails = 0;

  ibex_register_file_fpga_init #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(WZV)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .we_a_i(we), .waddr_a_i(waddr), .wdata_a_i(wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a[0]), .rf_rdata_b_i(rf_rdata_b[0]),
    .rdata_a_o(rdata_a[0]), .rdata_b_o(rdata_b[0]),
    .rf_we_o(rf_we[0]), .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]),
    .init_done_o(init_done[0]), .err_o(err[0])
  );

  ibex_register_file_fpga_init #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(WZV)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .we_a_i(we), .waddr_a_i(waddr), .wdata_a_i(wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a[1]), .rf_rdata_b_i(rf_rdata_b[1]),
    .rdata_a_o(rdata_a[1]), .rdata_b_o(rdata_b[1]),
    .rf_we_o(rf_we[1]), .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]),
    .init_done_o(init_done[1]), .err_o(err[1])
  );

  // Reset-less synchronous-write register files, preloaded with garbage.
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mem[k][i] = (i == 0) ? 32'h0 : PRE;
    end
  end
  always @(posedge clk) begin
    if (rf_we[0]) mem[0][rf_waddr[0]] <= rf_wdata[0];
    if (rf_we[1]) mem[1][rf_waddr[1]] <= rf_wdata[1];
  end
  assign rf_rdata_a[0] = mem[0][raddr_a];
  assign rf_rdata_b[0] = mem[0][raddr_b];
  assign rf_rdata_a[1] = mem[1][raddr_a];
  assign rf_rdata_b[1] = mem[1][raddr_b];

  // ---------------- reference model ----------------
  // Architectural view: what the core has written since reset, and where the
  // sweep pointer stands. Anything not written by the core reads WZV.
  logic        m_core [2][32];
  logic [31:0] m_val  [2][32];
  int          m_ptr  [2];
  logic        m_done [2];

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic m_cw(int k);
    return rst_n && we && (waddr != 5'd0) && !(k == 1 && waddr[4]);
  endfunction

  function automatic logic exp_we(int k);
    if (!rst_n) return 1'b0;
    if (m_cw(k)) return 1'b1;
    return !m_done[k] && !m_core[k][m_ptr[k]];
  endfunction

  function automatic logic [36:0] exp_wport(int k);
    if (m_cw(k)) return {waddr, wdata};
    return {5'(m_ptr[k]), WZV};
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (k == 1 && a[4]) return WZV;
    return m_core[k][a] ? m_val[k][a] : WZV;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_core[k][i] = 1'b0;
        m_ptr[k]  = 1;
        m_done[k] = 1'b0;
      end else if (m_cw(k)) begin
        m_core[k][waddr] = 1'b1;
        m_val[k][waddr]  = wdata;
      end else if (!m_done[k]) begin
        if (m_ptr[k] == nregs(k) - 1) m_done[k] = 1'b1;
        else m_ptr[k] = m_ptr[k] + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d);
    we      = w;
    waddr   = a;
    wdata   = d;
    raddr_a = 5'($urandom_range(0, 31));
    raddr_b = 5'($urandom_range(0, 31));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd17, 32'h5555_0000);
    #2;
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (rf_we[k] !== 1'b0 || err[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_gating dut%0d got we=%b err=%b want 0 0", k, rf_we[k], err[k]);
      end
    end
    tick();
    tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (init_done[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_done dut%0d got %b want 0", k, init_done[k]);
      end
    end
  endtask

  task automatic test_sweep_idle();
    int we_cnt [2];
    int done_at [2];
    we_cnt  = '{0, 0};
    done_at = '{-1, -1};
    do_reset(2);
    for (int c = 1; c <= 34; c++) begin
      drive(1'b0, 5'($urandom_range(0, 31)), $urandom);
      if (c == 3) begin
        raddr_a = 5'd20;
        raddr_b = 5'd0;
      end
      #2;
      for (int k = 0; k < 2; k++) begin
        if (rf_we[k]) we_cnt[k]++;
        vec++;
        if (rf_we[k] !== exp_we(k)) begin
          fails++;
          $display("FAIL sweep_we dut%0d cyc %0d got %b want %b", k, c, rf_we[k], exp_we(k));
        end
        if (exp_we(k)) begin
          vec++;
          if ({rf_waddr[k], rf_wdata[k]} !== exp_wport(k)) begin
            fails++;
            $display("FAIL sweep_wport dut%0d cyc %0d got %h want %h", k, c,
                     {rf_waddr[k], rf_wdata[k]}, exp_wport(k));
          end
        end
        vec++;
        if (rdata_a[k] !== exp_rd(k, raddr_a) || rdata_b[k] !== exp_rd(k, raddr_b)) begin
          fails++;
          $display("FAIL sweep_read dut%0d cyc %0d got %h/%h want %h/%h", k, c, rdata_a[k],
                   rdata_b[k], exp_rd(k, raddr_a), exp_rd(k, raddr_b));
        end
        if (c == 3) begin
          vec++;
          if (rdata_a[k] !== WZV || rdata_b[k] !== 32'h0) begin
            fails++;
            $display("FAIL stale_mask dut%0d got %h/%h want %h/0", k, rdata_a[k], rdata_b[k], WZV);
          end
        end
      end
      tick();
      #1;
      for (int k = 0; k < 2; k++) if (init_done[k] && done_at[k] < 0) done_at[k] = c;
    end
    vec++;
    if (we_cnt[0] !== 31 || we_cnt[1] !== 15) begin
      fails++;
      $display("FAIL sweep_len got %0d/%0d want 31/15", we_cnt[0], we_cnt[1]);
    end
    vec++;
    if (done_at[0] !== 31 || done_at[1] !== 15) begin
      fails++;
      $display("FAIL sweep_done_edge got %0d/%0d want 31/15", done_at[0], done_at[1]);
    end
  endtask

  task automatic test_core_write();
    int done_at [2];
    done_at = '{-1, -1};
    do_reset(2);
    for (int c = 1; c <= 36; c++) begin
      if (c == 2) drive(1'b1, 5'd5, 32'h1234);
      else drive(1'b0, 5'd0, 32'h0);
      #2;
      for (int k = 0; k < 2; k++) begin
        vec++;
        if (rf_we[k] !== exp_we(k)) begin
          fails++;
          $display("FAIL cw_we dut%0d cyc %0d got %b want %b", k, c, rf_we[k], exp_we(k));
        end
        if (exp_we(k)) begin
          vec++;
          if ({rf_waddr[k], rf_wdata[k]} !== exp_wport(k)) begin
            fails++;
            $display("FAIL cw_wport dut%0d cyc %0d got %h want %h", k, c,
                     {rf_waddr[k], rf_wdata[k]}, exp_wport(k));
          end
        end
        vec++;
        if (rdata_a[k] !== exp_rd(k, raddr_a) || rdata_b[k] !== exp_rd(k, raddr_b)) begin
          fails++;
          $display("FAIL cw_read dut%0d cyc %0d got %h/%h want %h/%h", k, c, rdata_a[k],
                   rdata_b[k], exp_rd(k, raddr_a), exp_rd(k, raddr_b));
        end
      end
      if (c == 2) begin
        vec++;
        if (rf_we[0] !== 1'b1 || rf_waddr[0] !== 5'd5 || rf_wdata[0] !== 32'h1234) begin
          fails++;
          $display("FAIL cw_priority got we=%b a=%0d d=%h want 1 5 1234", rf_we[0],
                   rf_waddr[0], rf_wdata[0]);
        end
      end
      tick();
      #1;
      for (int k = 0; k < 2; k++) if (init_done[k] && done_at[k] < 0) done_at[k] = c;
    end
    vec++;
    if (done_at[0] !== 32 || done_at[1] !== 16) begin
      fails++;
      $display("FAIL cw_done_edge got %0d/%0d want 32/16", done_at[0], done_at[1]);
    end
    raddr_a = 5'd5;
    #1;
    vec++;
    if (rdata_a[0] !== 32'h1234 || rdata_a[1] !== 32'h1234) begin
      fails++;
      $display("FAIL cw_readback got %h/%h want 1234", rdata_a[0], rdata_a[1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_at [2];
    done_at = '{-1, -1};
    do_reset(2);
    for (int c = 1; c <= 9; c++) tick();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h77);
    #2;
    vec++;
    if (rf_we !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset_we got %b want 00", rf_we);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      drive(1'b0, 5'd0, 32'h0);
      if (c == 1) raddr_b = 5'd5;
      #2;
      for (int k = 0; k < 2; k++) begin
        vec++;
        if (rf_we[k] !== exp_we(k) || (exp_we(k) && {rf_waddr[k], rf_wdata[k]} !== exp_wport(k))) begin
          fails++;
          $display("FAIL mid_wport dut%0d cyc %0d got %b %h want %b %h", k, c, rf_we[k],
                   {rf_waddr[k], rf_wdata[k]}, exp_we(k), exp_wport(k));
        end
        vec++;
        if (rdata_a[k] !== exp_rd(k, raddr_a) || rdata_b[k] !== exp_rd(k, raddr_b)) begin
          fails++;
          $display("FAIL mid_read dut%0d cyc %0d got %h/%h want %h/%h", k, c, rdata_a[k],
                   rdata_b[k], exp_rd(k, raddr_a), exp_rd(k, raddr_b));
        end
        if (c == 1) begin
          vec++;
          if (rdata_b[k] !== WZV) begin
            fails++;
            $display("FAIL mid_stale_x5 dut%0d got %h want %h", k, rdata_b[k], WZV);
          end
        end
      end
      tick();
      #1;
      for (int k = 0; k < 2; k++) if (init_done[k] && done_at[k] < 0) done_at[k] = c;
    end
    vec++;
    if (done_at[0] !== 31 || done_at[1] !== 15) begin
      fails++;
      $display("FAIL mid_done_edge got %0d/%0d want 31/15", done_at[0], done_at[1]);
    end
  endtask

  task automatic test_x0_and_rv32e();
    logic [31:0] v;
    v = $urandom;
    drive(1'b1, 5'd0, v);
    #2;
    vec++;
    if (rf_we !== 2'b00 || err !== 2'b00) begin
      fails++;
      $display("FAIL x0_write got we=%b err=%b want 00 00", rf_we, err);
    end
    tick();
    drive(1'b1, 5'd17, v);
    #2;
    vec++;
    if (err !== 2'b10 || rf_we !== 2'b01 || rf_waddr[0] !== 5'd17) begin
      fails++;
      $display("FAIL x17_write got err=%b we=%b a0=%0d want 10 01 17", err, rf_we, rf_waddr[0]);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0);
    raddr_a = 5'd17;
    #2;
    vec++;
    if (rdata_a[0] !== v || rdata_a[1] !== WZV) begin
      fails++;
      $display("FAIL x17_read got %h/%h want %h/%h", rdata_a[0], rdata_a[1], v, WZV);
    end
  endtask

  task automatic test_back_to_back();
    int done_at [2];
    done_at = '{-1, -1};
    do_reset(2);
    for (int c = 1; c <= 80; c++) begin
      if (c <= 40) drive(1'b1, 5'($urandom_range(1, 15)), $urandom);
      else drive(1'b0, 5'd0, 32'h0);
      #2;
      for (int k = 0; k < 2; k++) begin
        vec++;
        if (rf_we[k] !== exp_we(k) || (exp_we(k) && {rf_waddr[k], rf_wdata[k]} !== exp_wport(k))) begin
          fails++;
          $display("FAIL b2b_wport dut%0d cyc %0d got %b %h want %b %h", k, c, rf_we[k],
                   {rf_waddr[k], rf_wdata[k]}, exp_we(k), exp_wport(k));
        end
        vec++;
        if (rdata_a[k] !== exp_rd(k, raddr_a) || rdata_b[k] !== exp_rd(k, raddr_b)) begin
          fails++;
          $display("FAIL b2b_read dut%0d cyc %0d got %h/%h want %h/%h", k, c, rdata_a[k],
                   rdata_b[k], exp_rd(k, raddr_a), exp_rd(k, raddr_b));
        end
        if (c <= 41) begin
          vec++;
          if (init_done[k] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_starved dut%0d cyc %0d got %b want 0", k, c, init_done[k]);
          end
        end
      end
      tick();
      #1;
      for (int k = 0; k < 2; k++) if (init_done[k] && done_at[k] < 0) done_at[k] = c;
    end
    vec++;
    if (done_at[0] !== 71 || done_at[1] !== 55) begin
      fails++;
      $display("FAIL b2b_done_edge got %0d/%0d want 71/55", done_at[0], done_at[1]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sweep_idle();
    test_core_write();
    test_reset_mid_sweep();
    test_x0_and_rv32e();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
